// File: rtl/key_debounce_scan.sv
// key_debounce_scan
//   Reads N_KEYS raw active-low push-buttons, synchronises them into clk_24m,
//   debounces each against a shared tick and produces clean levels plus
//   single-cycle press / release / long-press events.
//
// Ports
//   clk_24m      in   system clock
//   rst          in   synchronous reset, active-high
//   key_in       in   [N_KEYS] raw pins, 0 = pressed, asynchronous
//   key_state    out  [N_KEYS] debounced level, 1 = pressed
//   key_press    out  [N_KEYS] 1-cycle pulse on accepted press
//   key_release  out  [N_KEYS] 1-cycle pulse on accepted release
//   key_long     out  [N_KEYS] 1-cycle pulse once per press after LONG_TICKS
//   tick         out  1-cycle pulse every TICK_DIV cycles
module key_debounce_scan #(
  parameter int N_KEYS     = 4,
  parameter int TICK_DIV   = 24000,
  parameter int DEB_TICKS  = 20,
  parameter int LONG_TICKS = 1000
) (
  input  logic              clk_24m,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic              tick
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEB_TICKS + 1);
  localparam int LW = $clog2(LONG_TICKS + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_TICKS);

  logic [N_KEYS-1:0] r_sync1;
  logic [N_KEYS-1:0] r_sync2;
  logic [TW-1:0]     r_tick_cnt;
  logic              w_tick;
  logic [N_KEYS-1:0] r_state;
  logic [N_KEYS-1:0] r_press;
  logic [N_KEYS-1:0] r_release;
  logic [N_KEYS-1:0] r_long;
  logic [N_KEYS-1:0] r_fired;
  logic [DW-1:0]     r_deb_cnt  [N_KEYS];
  logic [LW-1:0]     r_long_cnt [N_KEYS];

  // Two-flop synchroniser on the inverted pins so downstream logic sees 1 = pressed.
  always_ff @(posedge clk_24m) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= ~key_in;
      r_sync2 <= r_sync1;
    end
  end

  // Shared tick: high while the counter sits on its last value, then it wraps.
  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge clk_24m) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // Debounce: any cycle where the synchronised level matches the accepted level
  // restarts qualification; DEB_TICKS consecutive mismatching ticks flip it.
  always_ff @(posedge clk_24m) begin
    if (rst) begin
      r_state   <= '0;
      r_press   <= '0;
      r_release <= '0;
      for (int unsigned k = 0; k < N_KEYS; k++) begin
        r_deb_cnt[k] <= '0;
      end
    end else begin
      r_press   <= '0;
      r_release <= '0;
      for (int unsigned k = 0; k < N_KEYS; k++) begin
        if (r_sync2[k] == r_state[k]) begin
          r_deb_cnt[k] <= '0;
        end else if (w_tick) begin
          if (r_deb_cnt[k] + 1'b1 == DEB_LAST) begin
            r_state[k]   <= ~r_state[k];
            r_press[k]   <= ~r_state[k];
            r_release[k] <= r_state[k];
            r_deb_cnt[k] <= '0;
          end else begin
            r_deb_cnt[k] <= r_deb_cnt[k] + 1'b1;
          end
        end
      end
    end
  end

  // Long press: counts ticks while accepted-pressed; the fired flag freezes the
  // counter at LONG_TICKS so the event fires once per press.
  always_ff @(posedge clk_24m) begin
    if (rst) begin
      r_long  <= '0;
      r_fired <= '0;
      for (int unsigned k = 0; k < N_KEYS; k++) begin
        r_long_cnt[k] <= '0;
      end
    end else begin
      r_long <= '0;
      for (int unsigned k = 0; k < N_KEYS; k++) begin
        if (!r_state[k]) begin
          r_long_cnt[k] <= '0;
          r_fired[k]    <= 1'b0;
        end else if (w_tick && !r_fired[k]) begin
          r_long_cnt[k] <= r_long_cnt[k] + 1'b1;
          if (r_long_cnt[k] + 1'b1 == LONG_LAST) begin
            r_long[k]  <= 1'b1;
            r_fired[k] <= 1'b1;
          end
        end
      end
    end
  end

  assign key_state   = r_state;
  assign key_press   = r_press;
  assign key_release = r_release;
  assign key_long    = r_long;
  assign tick        = w_tick;

endmodule

// File: tb/tb_key_debounce_scan.sv
module tb_key_debounce_scan;

  localparam int NK = 4;
  localparam int TD = 4;
  localparam int DT = 3;
  localparam int LT = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_state;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_long;
  logic          tick;

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0;
  int r0  = 0;

  int n_press [NK];
  int n_rel   [NK];
  int n_long  [NK];
  int n_hi    [NK];
  int t_press [NK];
  int t_rel   [NK];
  int t_long  [NK];
  logic [NK-1:0] last_press_vec = '0;

  int c0, c1, ep, er, s_p, s_r, s_l, s_h, s_p3, s_r3, s_l3;

  key_debounce_scan #(
    .N_KEYS    (NK),
    .TICK_DIV  (TD),
    .DEB_TICKS (DT),
    .LONG_TICKS(LT)
  ) dut (
    .clk_24m    (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges seen so far
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int k = 0; k < NK; k++) begin
      n_press[k] = 0; n_rel[k] = 0; n_long[k] = 0; n_hi[k] = 0;
      t_press[k] = -1; t_rel[k] = -1; t_long[k] = -1;
    end
  end

  // Event monitor: pulse times are recorded as the index of the edge that raised them.
  always @(negedge clk) begin
    for (int k = 0; k < NK; k++) begin
      if (key_press[k])   begin n_press[k] <= n_press[k] + 1; t_press[k] <= cyc; end
      if (key_release[k]) begin n_rel[k]   <= n_rel[k] + 1;   t_rel[k]   <= cyc; end
      if (key_long[k])    begin n_long[k]  <= n_long[k] + 1;  t_long[k]  <= cyc; end
      if (key_state[k])   n_hi[k] <= n_hi[k] + 1;
    end
    if (key_press != '0) last_press_vec <= key_press;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int e);
    while (cyc < e) step();
  endtask

  // First tick edge at or after edge e; tick edges are r0 + 4k, k >= 1.
  function automatic int next_tick(input int e);
    int k;
    k = (e - r0 + TD - 1) / TD;
    if (k < 1) k = 1;
    return r0 + TD * k;
  endfunction

  // Edge at which a level driven just after edge c gets accepted.
  function automatic int accept_edge(input int c);
    return next_tick(c + 3) + (DT - 1) * TD;
  endfunction

  initial begin
    rst    = 1'b1;
    key_in = '1;
    step(); step(); step();
    rst = 1'b0;
    r0  = cyc;

    // 1: idle, tick every 4 cycles starting with cycle 4
    for (int c = 1; c <= 100; c++) begin
      check_eq("idle_tick", 32'(tick), 32'((c % TD) == 0));
      check_eq("idle_out", 32'({key_state, key_press, key_release, key_long}), 32'd0);
      step();
    end

    // 2: key 0 press, long, release
    c0 = cyc; s_p = n_press[0]; s_r = n_rel[0] + n_rel[1] + n_rel[2] + n_rel[3];
    key_in[0] = 1'b0;
    ep = accept_edge(c0);
    run_to(ep + 4);
    check_eq("k0_press_cnt", 32'(n_press[0] - s_p), 32'd1);
    check_eq("k0_press_time", 32'(t_press[0]), 32'(ep));
    check_eq("k0_latency_max", 32'(t_press[0] - c0 <= 14), 32'd1);
    check_eq("k0_state", 32'(key_state), 32'b0001);
    check_eq("k0_no_release", 32'(n_rel[0] + n_rel[1] + n_rel[2] + n_rel[3] - s_r), 32'd0);
    run_to(ep + 24);
    check_eq("k0_long_time", 32'(t_long[0]), 32'(ep + LT * TD));
    c1 = cyc; s_r = n_rel[0];
    key_in[0] = 1'b1;
    er = accept_edge(c1);
    run_to(er + 4);
    check_eq("k0_release_time", 32'(t_rel[0]), 32'(er));
    check_eq("k0_release_cnt", 32'(n_rel[0] - s_r), 32'd1);
    check_eq("k0_state_off", 32'(key_state), 32'd0);

    // 3: bounce on key 1 never qualifies
    s_p = n_press[1]; s_r = n_rel[1]; s_l = n_long[1]; s_h = n_hi[1];
    key_in[1] = 1'b0; repeat (6) step();
    key_in[1] = 1'b1; repeat (2) step();
    key_in[1] = 1'b0; repeat (6) step();
    key_in[1] = 1'b1; repeat (20) step();
    check_eq("k1_bounce_press", 32'(n_press[1] - s_p), 32'd0);
    check_eq("k1_bounce_rel", 32'(n_rel[1] - s_r), 32'd0);
    check_eq("k1_bounce_state", 32'(n_hi[1] - s_h), 32'd0);
    check_eq("k1_bounce_long", 32'(n_long[1] - s_l), 32'd0);

    // 4: key 2 held 60 cycles -> press, one long 20 cycles later, release
    c0 = cyc; s_p = n_press[2]; s_l = n_long[2]; s_r = n_rel[2];
    key_in[2] = 1'b0;
    ep = accept_edge(c0);
    repeat (60) step();
    check_eq("k2_press_cnt", 32'(n_press[2] - s_p), 32'd1);
    check_eq("k2_press_time", 32'(t_press[2]), 32'(ep));
    check_eq("k2_long_cnt", 32'(n_long[2] - s_l), 32'd1);
    check_eq("k2_long_gap", 32'(t_long[2] - t_press[2]), 32'(LT * TD));
    c1 = cyc;
    key_in[2] = 1'b1;
    er = accept_edge(c1);
    run_to(er + 4);
    check_eq("k2_release_time", 32'(t_rel[2]), 32'(er));
    check_eq("k2_release_win", 32'(t_rel[2] - c1 <= 14), 32'd1);
    check_eq("k2_release_cnt", 32'(n_rel[2] - s_r), 32'd1);
    check_eq("k2_long_once", 32'(n_long[2] - s_l), 32'd1);
    check_eq("k2_state_off", 32'(key_state), 32'd0);

    // 5: keys 0 and 3 together; key 3 released early enough to miss long
    c0 = cyc; s_p = n_press[0]; s_p3 = n_press[3]; s_r3 = n_rel[3]; s_l3 = n_long[3];
    s_l = n_long[0];
    key_in = 4'b0110;
    ep = accept_edge(c0);
    run_to(ep + 4);
    check_eq("k03_press_vec", 32'(last_press_vec), 32'b1001);
    check_eq("k0_press_t5", 32'(t_press[0]), 32'(ep));
    check_eq("k3_press_t5", 32'(t_press[3]), 32'(ep));
    check_eq("k03_state", 32'(key_state), 32'b1001);
    key_in[3] = 1'b1;
    er = accept_edge(cyc);
    run_to(ep + 24);
    check_eq("k3_release_time", 32'(t_rel[3]), 32'(er));
    check_eq("k3_release_cnt", 32'(n_rel[3] - s_r3), 32'd1);
    check_eq("k3_no_long", 32'(n_long[3] - s_l3), 32'd0);
    check_eq("k0_long_t5", 32'(t_long[0]), 32'(ep + LT * TD));
    check_eq("k0_long_cnt5", 32'(n_long[0] - s_l), 32'd1);
    c1 = cyc;
    key_in[0] = 1'b1;
    er = accept_edge(c1);
    run_to(er + 4);
    check_eq("k0_release_t5", 32'(t_rel[0]), 32'(er));
    check_eq("all_off_t5", 32'(key_state), 32'd0);

    // 6: reset while key 0 is pressed and mid long-count
    c0 = cyc;
    key_in[0] = 1'b0;
    ep = accept_edge(c0);
    run_to(ep + 2 * TD);
    check_eq("k0_pre_rst_state", 32'(key_state), 32'b0001);
    s_p = n_press[0]; s_l = n_long[0]; s_r = n_rel[0];
    rst = 1'b1;
    step();
    rst = 1'b0;
    r0 = cyc;
    check_eq("rst_outputs", 32'({key_state, key_press, key_release, key_long, tick}), 32'd0);
    ep = accept_edge(r0);
    run_to(ep + 4);
    check_eq("k0_rst_press_time", 32'(t_press[0]), 32'(ep));
    check_eq("k0_rst_press_cnt", 32'(n_press[0] - s_p), 32'd1);
    check_eq("k0_rst_no_stale_long", 32'(n_long[0] - s_l), 32'd0);
    run_to(ep + LT * TD + 4);
    check_eq("k0_rst_long_time", 32'(t_long[0]), 32'(ep + LT * TD));
    check_eq("k0_rst_long_cnt", 32'(n_long[0] - s_l), 32'd1);
    check_eq("k0_rst_no_release", 32'(n_rel[0] - s_r), 32'd0);
    check_eq("k0_rst_state", 32'(key_state), 32'b0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_debounce_scan.md
Name: key_debounce_scan

Overview:
- Input-side counterpart to the board LED drivers: reads N raw, active-low push-buttons in the clk_24m domain.
- Synchronises each key, debounces it against a shared millisecond tick and holds a clean level per key.
- Emits single-cycle press, release and long-press events for the demo control logic, e.g. start/stop/reverse of an LED pattern.

Parameters:
N_KEYS, 4, number of independent keys (1..16)
TICK_DIV, 24000, clk_24m cycles per debounce tick (1 ms at 24 MHz)
DEB_TICKS, 20, consecutive stable ticks required to accept a level change (20 ms)
LONG_TICKS, 1000, ticks a key must stay accepted-pressed to fire key_long (1 s)

Ports:
clk_24m  input  1  system clock, 24 MHz
rst  input  1  synchronous reset, active-high
key_in  input  N_KEYS  raw button pins, active-low (0 = pressed), asynchronous to clk_24m
key_state  output  N_KEYS  debounced level, 1 = pressed
key_press  output  N_KEYS  1-cycle pulse on accepted 0->1 of key_state
key_release  output  N_KEYS  1-cycle pulse on accepted 1->0 of key_state
key_long  output  N_KEYS  1-cycle pulse once per press after LONG_TICKS held
tick  output  1  1-cycle pulse every TICK_DIV cycles (exported for reuse)

Behaviour:
- Interface: one clock, clk_24m; reset rst is synchronous and active-high. Every register clears only on a clk_24m edge with rst=1.
- Reset values: all outputs 0. Sync flops, tick counter, debounce counters, long counters and long-fired flags all 0. All keys are treated as released.
- Synchroniser: two flops per key on the inverted input; key_sync = ~key_in delayed 2 cycles.
- Tick divider: counter runs 0..TICK_DIV-1. tick=1 in the cycle the counter equals TICK_DIV-1, then the counter wraps to 0. Width is clog2(TICK_DIV).
  - First tick after reset is asserted in the TICK_DIV-th cycle after rst deasserts.
- Per-key debounce counter: width clog2(DEB_TICKS+1).
  - key_sync == key_state: counter cleared to 0 every cycle. Any bounce restarts qualification.
  - key_sync != key_state and tick=1: counter increments.
  - Increment would reach DEB_TICKS: key_state toggles on that edge and the counter clears.
  - key_press or key_release is registered in the same edge, so the pulse is coincident with the first cycle of the new key_state.
- Latency: from key_in stable to key_state change is 2 cycles plus between (DEB_TICKS-1)*TICK_DIV+1 and DEB_TICKS*TICK_DIV cycles.
- Long press, per-key counter of width clog2(LONG_TICKS+1):
  - Increments on tick while key_state=1 and fired flag=0.
  - On reaching LONG_TICKS: key_long pulses one cycle, fired flag is set, counter holds (no wrap).
  - On key_state=0: counter and fired flag clear. A new press restarts counting.
  - key_long never coincides with key_press; the minimum gap is LONG_TICKS ticks.
- Keys are fully independent. Simultaneous events on different keys assert the corresponding bits in the same cycle.
- Release during long counting before LONG_TICKS: no key_long; key_release fires normally.
- rst mid-operation: everything clears on the next edge and no pulse is emitted during or after reset. A key held through reset is re-qualified as a fresh press, giving key_press after the full debounce time.
- key_in is never combinationally connected to any output.

Test Plan:
Use sim parameters N_KEYS=4, TICK_DIV=4, DEB_TICKS=3, LONG_TICKS=5.
1. Reset then idle key_in=4'hF for 100 cycles -> all outputs 0; tick pulses exactly every 4 cycles, first in cycle 4 after rst falls.
2. Drive key_in[0]=0 and hold -> exactly one key_press[0] pulse within 2+12 cycles; key_state=4'b0001 thereafter; key_release stays 0.
3. Bounce: key_in[1] low for 6 cycles, high 2, low 6, then high -> key_state[1] never set, no pulses on bit 1.
4. Hold key_in[2] low for 60 cycles -> key_press[2] once, then key_long[2] exactly once 5 ticks (20 cycles) after key_press[2], no repeat. On release -> key_release[2] once within 14 cycles; key_state[2]=0.
5. Press keys 0 and 3 on the same cycle -> key_press=4'b1001 in a single cycle. Release key 3 after 2 ticks -> key_release[3] pulses with no key_long[3].
6. Assert rst for 1 cycle while key 0 is debounced-pressed and its long counter is mid-count, then keep key 0 held -> outputs 0 during reset, then key_press[0] re-fires after the full debounce and key_long[0] 5 ticks later.
